vga_capture: RTL and testbench

- VGA receiver: samples the hsync/vsync/rgb stream produced by the vga generator and recovers the active pixel window.
- Pushes active pixels into a downstream FIFO write port using the same fifo_data/fifo_write/fifo_full protocol the line generator drives.
- Used for loopback self-test of the display path and for checking frame timing.
- Single clock domain (clk); the pixel rate is marked by a pix_en strobe.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_capture_sync_edge.sv | 28 ++
 rtl/vga_capture.sv | 142 ++++++++++++++
 tb/tb_vga_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: capture FSM states, 640x480 timing, CRC-16-CCITT constants.
// Used by the capture block and the generator so both agree on frame geometry.
package vga_pkg;

    typedef enum logic [2:0] {
        SEEK   = 3'd0,
        VBLANK = 3'd1,
        HWAIT  = 3'd2,
        ACTIVE = 3'd3,
        HLINE  = 3'd4
    } cap_state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = 525;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One 16-bit word, MSB first, non-reflected.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Sync edge detector: registers the previous sync level on pix_en, flags lead/trail edges.
// Latency: edges are combinational on the sampling pix_en cycle; no backpressure.
// History resets to the inactive level so a reset mid-sync never fakes a trailing edge.
module sync_edge #(
    parameter logic SYNC_ACT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic level,
    output logic lead,
    output logic trail
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= ~SYNC_ACT;
        end else if (pix_en) begin
            prev <= level;
        end
    end

    assign lead  = pix_en && (level == SYNC_ACT) && (prev != SYNC_ACT);
    assign trail = pix_en && (level != SYNC_ACT) && (prev == SYNC_ACT);

endmodule

// File: rtl/vga_capture.sv
// VGA capture: recovers the active window from hsync/vsync/rgb and writes pixels to a FIFO.
// Latency: fifo_write/fifo_data 1 clk after the sampling pix_en. Backpressure: fifo_full drops the pixel and sets overflow.
// Optional CAPTURE_CRC_EN adds frame_crc/crc_valid (CRC-16-CCITT over written pixels).
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_BP     = VGA_V_BP,
    parameter int SYNC_ACT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [15:0] fifo_data,
    output logic        frame_start,
    output logic        overflow,
    output logic [11:0] htotal,
    output logic        locked
`ifdef CAPTURE_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [11:0] H_FIRST = 12'(H_BP);
    localparam logic [11:0] H_LAST  = 12'(H_BP + H_ACTIVE - 1);
    localparam logic [10:0] V_PRE   = 11'(V_BP - 1);
    localparam logic [10:0] V_FIRST = 11'(V_BP);
    localparam logic [10:0] V_LAST  = 11'(V_BP + V_ACTIVE - 1);

    logic        h_lead, h_trail, v_lead, v_trail;
    logic [11:0] hcnt, hpos, lcnt, lcnt_inc;
    logic [10:0] vcnt;
    cap_state_t  state, state_nxt;
    logic        capture, first_pix;

    sync_edge #(.SYNC_ACT(1'(SYNC_ACT))) u_hsync (
        .clk(clk), .reset(reset), .pix_en(pix_en), .level(hsync), .lead(h_lead), .trail(h_trail)
    );
    sync_edge #(.SYNC_ACT(1'(SYNC_ACT))) u_vsync (
        .clk(clk), .reset(reset), .pix_en(pix_en), .level(vsync), .lead(v_lead), .trail(v_trail)
    );

    // hpos is the position of the pixel being sampled now; the trailing-edge sample is position 0.
    assign hpos     = h_trail ? 12'd0 : ((hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1);
    assign lcnt_inc = (lcnt == 12'hFFF) ? lcnt : lcnt + 12'd1;

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        first_pix = 1'b0;
        if (pix_en) begin
            unique case (state)
                SEEK:   if (v_trail) state_nxt = VBLANK;
                VBLANK: if (h_trail && vcnt == V_PRE) state_nxt = HWAIT;
                HWAIT: begin
                    if (hpos == H_FIRST) begin
                        capture   = 1'b1;
                        first_pix = (vcnt == V_FIRST);
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    capture = 1'b1;
                    if (hpos == H_LAST) state_nxt = (vcnt == V_LAST) ? VBLANK : HLINE;
                end
                HLINE:  if (h_trail) state_nxt = HWAIT;
                default: state_nxt = SEEK;
            endcase
            // A sample carrying a new vsync is blanking, never picture.
            if (v_lead && state != SEEK) begin
                state_nxt = VBLANK;
                capture   = 1'b0;
                first_pix = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SEEK;
            hcnt        <= '0;
            vcnt        <= '0;
            lcnt        <= '0;
            htotal      <= '0;
            locked      <= 1'b0;
            fifo_write  <= 1'b0;
            fifo_data   <= '0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            fifo_write  <= capture && !fifo_full;
            frame_start <= first_pix;
            if (pix_en) begin
                hcnt <= hpos;
                if (v_trail)      vcnt <= '0;
                else if (h_trail) vcnt <= vcnt + 11'd1;
                if (h_lead) begin
                    htotal <= lcnt_inc;
                    locked <= (lcnt_inc == htotal);
                    lcnt   <= '0;
                end else begin
                    lcnt <= lcnt_inc;
                end
                if (capture && !fifo_full) fifo_data <= rgb;
                // A drop on pixel 0 wins over the frame-start clear.
                if (first_pix)                  overflow <= fifo_full;
                else if (capture && fifo_full)  overflow <= 1'b1;
            end
        end
    end

`ifdef CAPTURE_CRC_EN
    logic frame_done, crc_pend;

    assign frame_done = capture && state == ACTIVE && hpos == H_LAST && vcnt == V_LAST;

    // crc_valid trails the last fifo_write by one clk, hence the extra stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_crc <= '0;
            crc_pend  <= 1'b0;
            crc_valid <= 1'b0;
        end else begin
            crc_pend  <= frame_done;
            crc_valid <= crc_pend;
            if (first_pix)                     frame_crc <= fifo_full ? CRC_INIT : crc16_step(CRC_INIT, rgb);
            else if (capture && !fifo_full)    frame_crc <= crc16_step(frame_crc, rgb);
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled 16x8 geometry; two DUTs (active-low and active-high syncs)
// see the same stream and are checked per pixel against a position-based reference model.
module tb_vga_capture;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 8, VFP = 1, VS = 2, VBP = 3;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync, vsync, fifo_full;
    logic        hsync_n, vsync_n;
    logic [15:0] rgb;
    logic        fw0, fs0, ov0, lk0, fw1, fs1, ov1, lk1;
    logic [15:0] fd0, fd1;
    logic [11:0] ht0, ht1;
`ifdef CAPTURE_CRC_EN
    logic [15:0] crc0, crc1;
    logic        cv0, cv1;
`endif

    assign hsync_n = ~hsync;
    assign vsync_n = ~vsync;

    always #5 clk = ~clk;

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(HBP), .V_BP(VBP), .SYNC_ACT(0)) dut0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .fifo_full(fifo_full), .fifo_write(fw0), .fifo_data(fd0), .frame_start(fs0),
        .overflow(ov0), .htotal(ht0), .locked(lk0)
`ifdef CAPTURE_CRC_EN
        , .frame_crc(crc0), .crc_valid(cv0)
`endif
    );

    vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BP(HBP), .V_BP(VBP), .SYNC_ACT(1)) dut1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync_n), .vsync(vsync_n), .rgb(rgb),
        .fifo_full(fifo_full), .fifo_write(fw1), .fifo_data(fd1), .frame_start(fs1),
        .overflow(ov1), .htotal(ht1), .locked(lk1)
`ifdef CAPTURE_CRC_EN
        , .frame_crc(crc1), .crc_valid(cv1)
`endif
    );

    int tests = 0, fails = 0;
    int wr0 = 0, wr1 = 0, fsc0 = 0, fsc1 = 0;
    int m_writes = 0;
    logic armed = 1'b0, m_ovf = 1'b0, m_vs_prev = 1'b0;
    logic [15:0] m_crc = 16'hFFFF;

    always @(negedge clk) begin
        if (fw0) wr0++;
        if (fw1) wr1++;
        if (fs0) fsc0++;
        if (fs1) fsc1++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef CAPTURE_CRC_EN
    // Long-division form: fold the whole word in, then reduce 16 times.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] v;
        v = c ^ d;
        for (int i = 0; i < 16; i++) v = v[15] ? ((v << 1) ^ 16'h1021) : (v << 1);
        return v;
    endfunction
`endif

    task automatic do_reset();
        reset  = 1'b0;
        pix_en = 1'b0;
        @(posedge clk); #1;
        check("reset_state_lo", {fw0, fs0, ov0, lk0, ht0}, 32'h0);
        check("reset_state_hi", {fw1, fs1, ov1, lk1, ht1}, 32'h0);
`ifdef CAPTURE_CRC_EN
        check("reset_crc", {cv0, cv1, crc0, crc1}, 32'h0);
`endif
        reset     = 1'b1;
        armed     = 1'b0;
        m_ovf     = 1'b0;
        m_vs_prev = 1'b0;
    endtask

    task automatic send_pix(input logic hs_act, input logic vs_act, input logic pix_act,
                            input logic fs_pos, input logic last_pos, input logic full);
        logic [15:0] d;
        logic cap, exp_w, exp_fs, exp_cv;
        d = 16'($urandom);
        hsync = ~hs_act; vsync = ~vs_act; rgb = d; fifo_full = full; pix_en = 1'b1;
        if (m_vs_prev && !vs_act) armed = 1'b1;
        m_vs_prev = vs_act;
        cap    = armed && pix_act;
        exp_w  = cap && !full;
        exp_fs = cap && fs_pos;
        exp_cv = cap && last_pos;
        if (exp_fs) m_ovf = full;
        else if (cap && full) m_ovf = 1'b1;
`ifdef CAPTURE_CRC_EN
        if (exp_fs) m_crc = 16'hFFFF;
        if (exp_w)  m_crc = crc_model(m_crc, d);
`endif
        if (exp_w) m_writes++;
        @(posedge clk); #1;
        pix_en = 1'b0; fifo_full = 1'($urandom); rgb = 16'($urandom);
        check("pixel_lo", {fw0, exp_w ? fd0 : 16'h0, fs0, ov0}, {exp_w, exp_w ? d : 16'h0, exp_fs, m_ovf});
        check("pixel_hi", {fw1, exp_w ? fd1 : 16'h0, fs1, ov1}, {exp_w, exp_w ? d : 16'h0, exp_fs, m_ovf});
        @(posedge clk); #1;
        check("pulse_width", {fw0, fs0, fw1, fs1}, 32'h0);
`ifdef CAPTURE_CRC_EN
        check("crc_valid", {cv0, cv1}, {exp_cv, exp_cv});
        if (exp_cv) check("frame_crc", {crc0, crc1}, {m_crc, m_crc});
`endif
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int nact, input int full_line, input int full_col,
                             input int full_len, input int rst_line, input bit rand_full);
        int nfp, nl;
        logic hs, vs, act, full;
        nfp = (nact == VA) ? VFP : 0;
        nl  = nact + nfp + VS + VBP;
        for (int l = 0; l < nl; l++) begin
            if (l == rst_line) do_reset();
            for (int c = 0; c < HT; c++) begin
                vs  = (l >= nact + nfp) && (l < nact + nfp + VS);
                hs  = (c >= HA + HFP) && (c < HA + HFP + HS);
                act = (l < nact) && (c < HA);
                if (rand_full) full = ($urandom_range(0, 7) == 0);
                else           full = (l == full_line) && (c >= full_col) && (c < full_col + full_len);
                send_pix(hs, vs, act, act && l == 0 && c == 0,
                         act && nact == VA && l == VA - 1 && c == HA - 1, full);
            end
        end
    endtask

    typedef struct {
        int nframes;
        int trunc_line;
        int full_line;
        int full_col;
        int full_len;
        int rst_line;
        bit rand_full;
        int exp_writes;
        int exp_fs;
        int exp_ovf;
    } scen_t;

    localparam int NS = 7;
    scen_t sc[NS];

    initial begin
        // settings apply to the first frame of each scenario; -1 = not used / not checked
        sc[0] = '{2, -1, -1, 0,  0, -1, 1'b0, 2 * HA * VA,           2,  0};
        sc[1] = '{1, -1,  5, 3, 10, -1, 1'b0, HA * VA - 10,          1,  1};
        sc[2] = '{1, -1, -1, 0,  0, -1, 1'b0, HA * VA,               1,  0};
        sc[3] = '{2, -1, -1, 0,  0,  4, 1'b0, 4 * HA + HA * VA,      2,  0};
        sc[4] = '{2,  5, -1, 0,  0, -1, 1'b0, 5 * HA + HA * VA,      2,  0};
        sc[5] = '{1, -1,  0, 0,  1, -1, 1'b0, HA * VA - 1,           1,  1};
        sc[6] = '{3, -1, -1, 0,  0, -1, 1'b1, -1,                    3, -1};

        reset = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        run_frame(0, -1, 0, 0, -1, 1'b0);

        for (int s = 0; s < NS; s++) begin
            int w0s, w1s, f0s, f1s, ms, nact;
            w0s = wr0; w1s = wr1; f0s = fsc0; f1s = fsc1; ms = m_writes;
            for (int f = 0; f < sc[s].nframes; f++) begin
                nact = (f == 0 && sc[s].trunc_line >= 0) ? sc[s].trunc_line : VA;
                if (f == 0) run_frame(nact, sc[s].full_line, sc[s].full_col, sc[s].full_len,
                                      sc[s].rst_line, sc[s].rand_full);
                else        run_frame(VA, -1, 0, 0, -1, 1'b0);
            end
            if (sc[s].exp_writes >= 0) begin
                check("writes_lo", wr0 - w0s, sc[s].exp_writes);
                check("writes_hi", wr1 - w1s, sc[s].exp_writes);
            end
            check("writes_model", wr0 - w0s, m_writes - ms);
            check("frame_starts_lo", fsc0 - f0s, sc[s].exp_fs);
            check("frame_starts_hi", fsc1 - f1s, sc[s].exp_fs);
            if (sc[s].exp_ovf >= 0) check("overflow_end", {ov0, ov1}, {2{sc[s].exp_ovf[0]}});
            check("htotal", {ht0, ht1}, {12'(HT), 12'(HT)});
            check("locked", {lk0, lk1}, 2'b11);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
